// File: rtl/painel_contador.sv
// Board counter panel: prescaled up/down/load counter with wrap or saturate overflow,
// sticky overflow flag, 7-segment hex decode of the low nibble and an FSM state for the LCD.
module painel_contador #(
    parameter int NBITS    = 8,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk_2,
    input  logic             reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [NBITS-1:0] load_value,
    input  logic             clr_ovf,
    output logic [NBITS-1:0] count,
    output logic [NBITS-1:0] LED,
    output logic [7:0]       SEG,
    output logic             ovf,
    output logic             wrap,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        ST_HOLD = 3'd0,
        ST_UP   = 3'd1,
        ST_DOWN = 3'd2,
        ST_LOAD = 3'd3,
        ST_SAT  = 3'd4
    } state_t;

    localparam logic [1:0] M_HOLD = 2'b00;
    localparam logic [1:0] M_UP   = 2'b01;
    localparam logic [1:0] M_DOWN = 2'b10;
    localparam logic [1:0] M_LOAD = 2'b11;

    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    state_t           r_state, w_state;
    logic [NBITS-1:0] r_count, w_count;
    logic [PW-1:0]    r_pre, w_pre, w_pre_eff;
    logic [1:0]       r_prev_mode;
    logic             r_ovf, w_ovf_set;
    logic             r_wrap, w_wrap;
    logic             r_sat_dir, w_sat_dir;     // 0 = clamped at max (UP), 1 = clamped at 0 (DOWN)
    logic             w_updown, w_tick, w_sat_stay;
    logic [6:0]       w_seg7;

    // A direction change restarts the prescaler as if counting had just begun.
    assign w_updown   = (mode == M_UP) || (mode == M_DOWN);
    assign w_pre_eff  = (mode != r_prev_mode) ? '0 : r_pre;
    assign w_tick     = en && w_updown && (w_pre_eff == PRE_MAX);
    assign w_sat_stay = (r_state == ST_SAT) &&
                        ((!r_sat_dir && mode == M_UP) || (r_sat_dir && mode == M_DOWN));

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        w_state   = r_state;
        w_count   = r_count;
        w_wrap    = 1'b0;
        w_ovf_set = 1'b0;
        w_sat_dir = r_sat_dir;

        if (!w_updown)  w_pre = '0;
        else if (!en)   w_pre = w_pre_eff;
        else if (w_tick) w_pre = '0;
        else            w_pre = w_pre_eff + PW'(1);

        case (mode)
            M_HOLD: w_state = ST_HOLD;
            M_LOAD: begin
                w_state = ST_LOAD;
                w_count = load_value;
            end
            M_UP: begin
                if (w_sat_stay) begin
                    w_state = ST_SAT;
                end else begin
                    w_state = ST_UP;
                    if (w_tick) begin
                        if (&r_count) begin
                            w_wrap    = 1'b1;
                            w_ovf_set = 1'b1;
                            if (SATURATE != 0) begin
                                w_state   = ST_SAT;
                                w_sat_dir = 1'b0;
                            end else begin
                                w_count = '0;
                            end
                        end else begin
                            w_count = r_count + NBITS'(1);
                        end
                    end
                end
            end
            default: begin  // M_DOWN
                if (w_sat_stay) begin
                    w_state = ST_SAT;
                end else begin
                    w_state = ST_DOWN;
                    if (w_tick) begin
                        if (r_count == '0) begin
                            w_wrap    = 1'b1;
                            w_ovf_set = 1'b1;
                            if (SATURATE != 0) begin
                                w_state   = ST_SAT;
                                w_sat_dir = 1'b1;
                            end else begin
                                w_count = '1;
                            end
                        end else begin
                            w_count = r_count - NBITS'(1);
                        end
                    end
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_HOLD;
            r_count     <= '0;
            r_pre       <= '0;
            r_prev_mode <= M_HOLD;
            r_ovf       <= 1'b0;
            r_wrap      <= 1'b0;
            r_sat_dir   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_count     <= w_count;
            r_pre       <= w_pre;
            r_prev_mode <= mode;
            r_wrap      <= w_wrap;
            r_sat_dir   <= w_sat_dir;
            if (w_ovf_set)    r_ovf <= 1'b1;
            else if (clr_ovf) r_ovf <= 1'b0;
        end
    end

    always_comb begin
        w_seg7 = 7'h00;
        case (r_count[3:0])
            4'h0: w_seg7 = 7'h3F;
            4'h1: w_seg7 = 7'h06;
            4'h2: w_seg7 = 7'h5B;
            4'h3: w_seg7 = 7'h4F;
            4'h4: w_seg7 = 7'h66;
            4'h5: w_seg7 = 7'h6D;
            4'h6: w_seg7 = 7'h7D;
            4'h7: w_seg7 = 7'h07;
            4'h8: w_seg7 = 7'h7F;
            4'h9: w_seg7 = 7'h6F;
            4'hA: w_seg7 = 7'h77;
            4'hB: w_seg7 = 7'h7C;
            4'hC: w_seg7 = 7'h39;
            4'hD: w_seg7 = 7'h5E;
            4'hE: w_seg7 = 7'h79;
            default: w_seg7 = 7'h71;
        endcase
    end

    assign count   = r_count;
    assign LED     = r_count;
    assign SEG     = {r_ovf, w_seg7};
    assign ovf     = r_ovf;
    assign wrap    = r_wrap;
    assign state_o = r_state;

endmodule

// File: tb/tb_painel_contador.sv
// Directed bench for painel_contador: four instances cover wrap, prescale 4, saturate and prescale 3.
module tb_painel_contador;

    logic       clk_2;
    logic       reset_n;
    logic       en;
    logic [1:0] mode;
    logic [7:0] load_value;
    logic       clr_ovf;

    logic [7:0] count_a, led_a, seg_a;  logic ovf_a, wrap_a;  logic [2:0] st_a;
    logic [7:0] count_b, led_b, seg_b;  logic ovf_b, wrap_b;  logic [2:0] st_b;
    logic [7:0] count_c, led_c, seg_c;  logic ovf_c, wrap_c;  logic [2:0] st_c;
    logic [7:0] count_d, led_d, seg_d;  logic ovf_d, wrap_d;  logic [2:0] st_d;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] HOLD = 2'b00, UP = 2'b01, DOWN = 2'b10, LOAD = 2'b11;

    painel_contador #(.NBITS(8), .PRESCALE(1), .SATURATE(0)) dut_a (
        .clk_2(clk_2), .reset_n(reset_n), .en(en), .mode(mode), .load_value(load_value),
        .clr_ovf(clr_ovf), .count(count_a), .LED(led_a), .SEG(seg_a), .ovf(ovf_a),
        .wrap(wrap_a), .state_o(st_a));

    painel_contador #(.NBITS(8), .PRESCALE(4), .SATURATE(0)) dut_b (
        .clk_2(clk_2), .reset_n(reset_n), .en(en), .mode(mode), .load_value(load_value),
        .clr_ovf(clr_ovf), .count(count_b), .LED(led_b), .SEG(seg_b), .ovf(ovf_b),
        .wrap(wrap_b), .state_o(st_b));

    painel_contador #(.NBITS(8), .PRESCALE(1), .SATURATE(1)) dut_c (
        .clk_2(clk_2), .reset_n(reset_n), .en(en), .mode(mode), .load_value(load_value),
        .clr_ovf(clr_ovf), .count(count_c), .LED(led_c), .SEG(seg_c), .ovf(ovf_c),
        .wrap(wrap_c), .state_o(st_c));

    painel_contador #(.NBITS(8), .PRESCALE(3), .SATURATE(0)) dut_d (
        .clk_2(clk_2), .reset_n(reset_n), .en(en), .mode(mode), .load_value(load_value),
        .clr_ovf(clr_ovf), .count(count_d), .LED(led_d), .SEG(seg_d), .ovf(ovf_d),
        .wrap(wrap_d), .state_o(st_d));

    initial begin
        clk_2 = 1'b0;
        forever #5 clk_2 = ~clk_2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one active edge and sample 1 ns after it.
    task automatic step();
        @(posedge clk_2);
        #1;
    endtask

    task automatic apply_reset();
        reset_n    = 1'b0;
        mode       = HOLD;
        en         = 1'b0;
        clr_ovf    = 1'b0;
        load_value = 8'h00;
        @(posedge clk_2);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1; en = 1'b0; mode = HOLD; load_value = 8'h00; clr_ovf = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        check("rst_count", count_a, 8'h00);
        check("rst_seg",   seg_a,   8'h3F);
        check("rst_ovf",   ovf_a,   1'b0);
        check("rst_wrap",  wrap_a,  1'b0);
        check("rst_state", st_a,    3'd0);
        @(posedge clk_2); #1;
        reset_n = 1'b1;

        // Wrap at max with PRESCALE=1.
        mode = LOAD; load_value = 8'hFE; en = 1'b1;
        step(); check("ld_count", count_a, 8'hFE); check("ld_state", st_a, 3'd3);
        mode = UP;
        step(); check("up1_count", count_a, 8'hFF); check("up1_wrap", wrap_a, 1'b0);
        check("up1_state", st_a, 3'd1);
        step(); check("up2_count", count_a, 8'h00); check("up2_wrap", wrap_a, 1'b1);
        check("up2_ovf", ovf_a, 1'b1);
        step(); check("up3_count", count_a, 8'h01); check("up3_wrap", wrap_a, 1'b0);
        check("up3_seg", seg_a, 8'h86); check("up3_led", led_a, 8'h01);

        // Sticky overflow clear and set-over-clear priority.
        mode = HOLD; clr_ovf = 1'b1;
        step(); check("clr_ovf", ovf_a, 1'b0); check("clr_seg", seg_a, 8'h06);
        clr_ovf = 1'b0; mode = LOAD; load_value = 8'hFF;
        step(); check("ld_ff_ovf", ovf_a, 1'b0);
        mode = UP; clr_ovf = 1'b1;
        step(); check("setclr_ovf", ovf_a, 1'b1); check("setclr_wrap", wrap_a, 1'b1);
        check("setclr_seg", seg_a, 8'hBF);
        clr_ovf = 1'b0; mode = DOWN;
        step(); check("under_count", count_a, 8'hFF); check("under_wrap", wrap_a, 1'b1);
        check("under_state", st_a, 3'd2);

        // Prescale 4 with an en gap.
        apply_reset();
        mode = UP; en = 1'b1;
        step(); step(); step(); check("ps4_e3", count_b, 8'h00);
        step(); check("ps4_e4", count_b, 8'h01);
        step(); check("ps4_e5", count_b, 8'h01);
        en = 1'b0;
        step(); step(); check("ps4_e7", count_b, 8'h01);
        en = 1'b1;
        step(); step(); check("ps4_e9", count_b, 8'h01);
        step(); check("ps4_e10", count_b, 8'h02);

        // Saturation at 0, exit to UP, saturation at max, exit to DOWN.
        apply_reset();
        mode = LOAD; load_value = 8'h01; en = 1'b1;
        step(); check("sat_ld", count_c, 8'h01);
        mode = DOWN;
        step(); check("sat_d1_count", count_c, 8'h00); check("sat_d1_wrap", wrap_c, 1'b0);
        step(); check("sat_d2_count", count_c, 8'h00); check("sat_d2_wrap", wrap_c, 1'b1);
        check("sat_d2_state", st_c, 3'd4); check("sat_d2_ovf", ovf_c, 1'b1);
        step(); check("sat_d3_wrap", wrap_c, 1'b0); check("sat_d3_state", st_c, 3'd4);
        step(); check("sat_d4_count", count_c, 8'h00); check("sat_d4_wrap", wrap_c, 1'b0);
        mode = UP;
        step(); check("sat_up_count", count_c, 8'h01); check("sat_up_state", st_c, 3'd1);
        check("sat_up_seg", seg_c, 8'h86);
        mode = LOAD; load_value = 8'hFF;
        step();
        mode = UP;
        step(); check("satmax_count", count_c, 8'hFF); check("satmax_wrap", wrap_c, 1'b1);
        check("satmax_state", st_c, 3'd4);
        step(); check("satmax2_wrap", wrap_c, 1'b0); check("satmax2_count", count_c, 8'hFF);
        mode = DOWN;
        step(); check("satmax_dn_count", count_c, 8'hFE); check("satmax_dn_state", st_c, 3'd2);
        mode = LOAD; load_value = 8'h00;
        step();
        mode = DOWN;
        step(); check("sat0_wrap", wrap_c, 1'b1);
        reset_n = 1'b0;
        #2;
        check("midrst_count", count_c, 8'h00); check("midrst_wrap", wrap_c, 1'b0);
        check("midrst_state", st_c, 3'd0); check("midrst_ovf", ovf_c, 1'b0);
        check("midrst_seg", seg_c, 8'h3F);
        @(posedge clk_2); #1;
        reset_n = 1'b1;

        // Prescale 3 restart across an UP-HOLD-UP toggle.
        apply_reset();
        mode = UP; en = 1'b1;
        step(); step(); check("ps3_e2", count_d, 8'h00);
        step(); check("ps3_e3", count_d, 8'h01);
        step();
        mode = HOLD;
        step(); check("ps3_hold", count_d, 8'h01); check("ps3_hold_state", st_d, 3'd0);
        mode = UP;
        step(); step(); check("ps3_e7", count_d, 8'h01);
        step(); check("ps3_e8", count_d, 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/painel_contador.md
Name: painel_contador

Overview:
- Parametrised successor to the lab board's switch-to-LED/SEG/LCD top-level logic for the LOAC board.
- Implements a registered up/down/load counter with a prescaler, wrap or saturate overflow policy, a sticky overflow flag and an on-board 7-segment hex decode.
- Instantiated by the board top: switches drive the control inputs; LED, SEG and the LCD debug fields are driven from its outputs.

Parameters:
- NBITS, 8, counter/load/LED width (≥4).
- PRESCALE, 1, enabled cycles per count step (≥1).
- SATURATE, 0, overflow policy: 0 = wrap around, 1 = clamp at limit.

Ports:
- clk_2  input  1  board clock.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable, synchronous to clk_2.
- mode  input  2  00 HOLD, 01 UP, 10 DOWN, 11 LOAD.
- load_value  input  NBITS  value loaded in LOAD mode.
- clr_ovf  input  1  synchronous clear of the sticky overflow flag.
- count  output  NBITS  current counter value.
- LED  output  NBITS  equals count.
- SEG  output  8  [6:0] = segments a..g (active-high) for count[3:0]; [7] = ovf.
- ovf  output  1  sticky overflow/underflow flag.
- wrap  output  1  one-cycle pulse on the edge where a limit is crossed or hit.
- state_o  output  3  FSM state for the LCD: HOLD=0, UP=1, DOWN=2, LOAD=3, SAT=4.

Behaviour:
- Reset (asynchronous, reset_n=0) forces:
  - count=0, prescaler pre=0, ovf=0, wrap=0, sat_dir=0, state=HOLD.
  - SEG=8'h3F (digit '0', dp off).
  - Release takes effect at the first clk_2 edge with reset_n=1.
- All inputs are sampled on the rising edge of clk_2. The action at edge k uses mode/en at edge k; count and state_o update at that same edge (1-cycle latency from input to output).
- Prescaler:
  - tick = en & (mode is UP or DOWN) & (pre == PRESCALE-1).
  - When en & (UP or DOWN): pre ← tick ? 0 : pre+1.
  - When mode is HOLD or LOAD, or when mode differs from the previous edge's mode: pre ← 0.
  - en=0 in UP/DOWN freezes pre.
  - PRESCALE=1 gives tick every enabled cycle.
- HOLD: count unchanged; state=HOLD.
- LOAD: count ← load_value every edge; en is ignored; ovf unchanged; wrap=0; state=LOAD.
- UP on tick:
  - Below max: count+1.
  - At max (all ones), SATURATE=0: count ← 0, wrap=1, ovf ← 1.
  - At max, SATURATE=1: count held, wrap=1 on first hit only, ovf ← 1, state ← SAT, sat_dir=up.
- DOWN on tick: symmetric to UP.
  - At 0, SATURATE=0: count ← max, wrap=1, ovf ← 1.
  - At 0, SATURATE=1: clamp at 0, state ← SAT, sat_dir=down.
- SAT state:
  - Stays SAT while mode equals sat_dir's mode; no further wrap pulses; count held.
  - Any other mode leaves SAT at that edge and performs that mode's action.
  - Example: DOWN from max-saturation decrements on its first tick.
- wrap is 0 on every edge without a limit event; it never stays high for 2 cycles unless two consecutive ticks both cross the limit (PRESCALE=1, SATURATE=0, NBITS small).
- ovf:
  - Set takes priority over clr_ovf on the same edge.
  - clr_ovf alone clears it the next edge.
  - Not cleared by mode changes.
- SEG hex decode is combinational from count[3:0]:
  - Values 0-F map to standard a..g patterns: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71.
  - SEG[7]=ovf.
- All arithmetic is modulo 2^NBITS; no X propagation from load_value when not in LOAD.
- reset_n asserted mid-count or mid-SAT: immediate return to the reset values; no wrap pulse is generated.

Test Plan:
1. Reset with reset_n low mid-stream → count=0, SEG=8'h3F, ovf=0, state_o=0, all asynchronous before the next edge.
2. NBITS=8, SATURATE=0, PRESCALE=1: LOAD 8'hFE, then UP with en=1 for 3 edges → count FF,00,01; wrap high only on the 00 edge; ovf=1; SEG=8'h86 at count 01.
3. PRESCALE=4: UP with en=1 from 0 → count increments on edges 4,8,12. Drop en for 2 cycles after edge 5 → next increment delayed to edge 10.
4. SATURATE=1: LOAD 8'h01, DOWN for 4 ticks → count 00 then held; wrap pulses once; state_o=4; switch to UP → count=01 next tick, state_o=1.
5. With ovf=1, assert clr_ovf alone → ovf=0 next edge. Assert clr_ovf on the same edge as a wrap → ovf stays 1.
6. Toggle mode UP→HOLD→UP with PRESCALE=3 → pre restarts at 0; first post-toggle increment occurs 3 enabled cycles after returning to UP.
